button_event_gen: RTL



---
 rtl/button_event_gen_if.sv | 38 +++
 rtl/button_event_gen.sv | 120 ++++++++++++
 2 files changed

// File: rtl/button_event_gen_if.sv
// Event bundle between the button event generator and its consumer.
// Carries the debounced level in and the one-cycle event strobes out.
//   clean         - debounced button level (1 = pressed)
//   press_pulse   - strobe on press
//   release_pulse - strobe on release
//   short_press   - strobe on release before the long threshold
//   long_press    - strobe when the hold reaches the long threshold
//   repeat_pulse  - periodic strobe while held after long_press
//   held          - level, high while a press is in progress
interface button_event_gen_if;
    logic clean;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic repeat_pulse;
    logic held;

    modport master (
        input  clean,
        output press_pulse,
        output release_pulse,
        output short_press,
        output long_press,
        output repeat_pulse,
        output held
    );

    modport slave (
        output clean,
        input  press_pulse,
        input  release_pulse,
        input  short_press,
        input  long_press,
        input  repeat_pulse,
        input  held
    );
endinterface

// File: rtl/button_event_gen.sv
// Turns a clean, debounced button level into registered one-cycle events:
// press, release, short press, long press and auto-repeat while held.
//   clk - system clock, rising edge
//   rst - synchronous, active-high reset
//   bus - event bundle (master side): clean in, strobes and held out
module button_event_gen #(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_W         = 26
) (
    input  logic                clk,
    input  logic                rst,
    button_event_gen_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_CYCLES);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             prev;
    logic             rise;

    logic press_q, release_q, short_q, long_q, repeat_q, held_q;
    logic press_n, release_n, short_n, long_n, repeat_n, held_n;

    assign rise    = bus.clean & ~prev;
    assign cnt_inc = cnt + 1'b1;

    // Release always wins over a threshold or repeat on the same edge.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        short_n   = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_n = PRESS;
                    cnt_n   = '0;
                    press_n = 1'b1;
                end
            end
            PRESS: begin
                if (!bus.clean) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    release_n = 1'b1;
                    short_n   = 1'b1;
                end else if (cnt_inc == LONG_C) begin
                    state_n = LONG;
                    cnt_n   = '0;
                    long_n  = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            LONG: begin
                if (!bus.clean) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    release_n = 1'b1;
                end else if (cnt_inc == REPEAT_C) begin
                    cnt_n    = '0;
                    repeat_n = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        held_n = (state_n != IDLE);
    end

    // prev resets high so a button held through reset needs a release
    // before it can register a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            prev      <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            prev      <= bus.clean;
            press_q   <= press_n;
            release_q <= release_n;
            short_q   <= short_n;
            long_q    <= long_n;
            repeat_q  <= repeat_n;
            held_q    <= held_n;
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.short_press   = short_q;
    assign bus.long_press    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = held_q;

endmodule
